// File: rtl/matmul_engine_pkg.sv
// ============================================================================
// matmul_engine_pkg : shared sequencer state encoding for the matrix engine
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package matmul_engine_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_MAC  = 3'd3,
    S_WR   = 3'd4,
    S_DONE = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/matmul_engine_mac.sv
// ============================================================================
// matmul_engine_mac : unsigned multiply-accumulate with wrap/saturate overflow
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module matmul_engine_mac #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 16,
  parameter int SATURATE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [ACC_W-1:0]  o_acc,
  output logic              o_ovf_evt
);

  if (ACC_W < 2 * DATA_W) begin : g_acc_w_check
    $error("matmul_engine_mac: ACC_W must be >= 2*DATA_W");
  end

  logic [ACC_W-1:0]    r_acc;
  logic [2*DATA_W-1:0] w_prod;
  logic [ACC_W:0]      w_sum;
  logic [ACC_W-1:0]    w_next;

  assign w_prod = {{DATA_W{1'b0}}, i_a} * {{DATA_W{1'b0}}, i_b};
  assign w_sum  = {1'b0, r_acc} + {{(ACC_W + 1 - 2 * DATA_W){1'b0}}, w_prod};

  // Carry out of the ACC_W-bit sum is the overflow condition in both modes.
  assign w_next    = (w_sum[ACC_W] && (SATURATE != 0)) ? '1 : w_sum[ACC_W-1:0];
  assign o_ovf_evt = i_en & w_sum[ACC_W];
  assign o_acc     = r_acc;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/matmul_engine.sv
// ============================================================================
// matmul_engine : FSM-sequenced C = A x B over a shared synchronous memory
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module matmul_engine
  import matmul_engine_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 16,
  parameter int ADDR_W   = 16,
  parameter int DIM_W    = 8,
  parameter int SATURATE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DIM_W-1:0]  dim_m,
  input  logic [DIM_W-1:0]  dim_n,
  input  logic [DIM_W-1:0]  dim_p,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_c,
  input  logic [DATA_W-1:0] dm_in,
  output logic [ADDR_W-1:0] addr_dm,
  output logic              dm_wr,
  output logic [ACC_W-1:0]  to_mem,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic              dim_err
);

  localparam logic [DIM_W-1:0] c_one = DIM_W'(1);

  state_t            r_state;
  logic [DIM_W-1:0]  r_m, r_n, r_p, r_i, r_j, r_k;
  logic [ADDR_W-1:0] r_base_b, r_a_row, r_a_ptr, r_b_col, r_b_ptr, r_c_ptr, r_addr;
  logic [DATA_W-1:0] r_a;
  logic              r_wr, r_busy, r_done, r_ovf, r_dim_err;

  logic [ADDR_W-1:0] w_n_ext, w_p_ext;
  logic              w_i_last, w_j_last, w_k_last;
  logic              w_mac_en, w_mac_clr, w_ovf_evt;
  logic [ACC_W-1:0]  w_acc;

  assign w_n_ext  = ADDR_W'(r_n);
  assign w_p_ext  = ADDR_W'(r_p);
  assign w_i_last = (r_i == r_m - c_one);
  assign w_j_last = (r_j == r_p - c_one);
  assign w_k_last = (r_k == r_n - c_one);

  assign w_mac_en  = (r_state == S_MAC);
  assign w_mac_clr = (r_state == S_WR) || ((r_state == S_IDLE) && start);

  matmul_engine_mac #(
    .DATA_W   (DATA_W),
    .ACC_W    (ACC_W),
    .SATURATE (SATURATE)
  ) u_mac (
    .clk       (clk),
    .reset     (reset),
    .i_en      (w_mac_en),
    .i_clr     (w_mac_clr),
    .i_a       (r_a),
    .i_b       (dm_in),
    .o_acc     (w_acc),
    .o_ovf_evt (w_ovf_evt)
  );

  // Outputs are registered with the state they belong to, so addr_dm is
  // already valid during RD_A/RD_B and the read data lands one state later.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_m       <= '0;
      r_n       <= '0;
      r_p       <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_base_b  <= '0;
      r_a_row   <= '0;
      r_a_ptr   <= '0;
      r_b_col   <= '0;
      r_b_ptr   <= '0;
      r_c_ptr   <= '0;
      r_addr    <= '0;
      r_a       <= '0;
      r_wr      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
      r_dim_err <= 1'b0;
    end else begin
      r_wr   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_addr <= '0;
          r_busy <= 1'b0;
          if (start) begin
            r_m      <= dim_m;
            r_n      <= dim_n;
            r_p      <= dim_p;
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_base_b <= base_b;
            r_a_row  <= base_a;
            r_a_ptr  <= base_a;
            r_b_col  <= base_b;
            r_b_ptr  <= base_b;
            r_c_ptr  <= base_c;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b1;
            if ((dim_m == '0) || (dim_n == '0) || (dim_p == '0)) begin
              r_dim_err <= 1'b1;
              r_done    <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_dim_err <= 1'b0;
              r_addr    <= base_a;
              r_state   <= S_RD_A;
            end
          end
        end
        S_RD_A: begin
          r_addr  <= r_b_ptr;
          r_state <= S_RD_B;
        end
        S_RD_B: begin
          r_a     <= dm_in;
          r_addr  <= '0;
          r_state <= S_MAC;
        end
        S_MAC: begin
          if (w_ovf_evt) begin
            r_ovf <= 1'b1;
          end
          if (w_k_last) begin
            r_addr  <= r_c_ptr;
            r_wr    <= 1'b1;
            r_state <= S_WR;
          end else begin
            r_k     <= r_k + c_one;
            r_a_ptr <= r_a_ptr + 1'b1;
            r_b_ptr <= r_b_ptr + w_p_ext;
            r_addr  <= r_a_ptr + 1'b1;
            r_state <= S_RD_A;
          end
        end
        S_WR: begin
          r_k     <= '0;
          r_c_ptr <= r_c_ptr + 1'b1;
          if (w_j_last) begin
            r_j <= '0;
            if (w_i_last) begin
              r_addr  <= '0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              // Next row of A; B restarts at its first column.
              r_i     <= r_i + c_one;
              r_a_row <= r_a_row + w_n_ext;
              r_a_ptr <= r_a_row + w_n_ext;
              r_addr  <= r_a_row + w_n_ext;
              r_b_col <= r_base_b;
              r_b_ptr <= r_base_b;
              r_state <= S_RD_A;
            end
          end else begin
            r_j     <= r_j + c_one;
            r_b_col <= r_b_col + 1'b1;
            r_b_ptr <= r_b_col + 1'b1;
            r_a_ptr <= r_a_row;
            r_addr  <= r_a_row;
            r_state <= S_RD_A;
          end
        end
        S_DONE: begin
          r_addr  <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_addr  <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign addr_dm = r_addr;
  assign dm_wr   = r_wr;
  assign to_mem  = w_acc;
  assign busy    = r_busy;
  assign done    = r_done;
  assign ovf     = r_ovf;
  assign dim_err = r_dim_err;

endmodule

`default_nettype wire
